cntrl_spi_regs: RTL
===================

# cntrl_spi_regs

Control-register file and sequencer behind `spi_slave`. It decodes the 7-bit register address and the one-cycle write/read strobes, and drives the board control outputs: resets, IRQ, LEDs, DDC and I2S mux. It also runs a prefetch state machine that reads the ADC dual-port RAM, so DPRAM data is ready in the readback register before `spi_slave` starts shifting it out on MISO.

## Interface
- `ID_VALUE`, 32'h1C0A0001, constant returned by the ID register
- `DPRAM_AW`, 12, DPRAM address width
- `DPRAM_RD_LAT`, 2, DPRAM read latency in `clk` cycles (1..7)
- `RST_PULSE_LEN`, 16, length in cycles of each self-clearing reset pulse (2..255)

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `spi_addr`  in  7  register address from `spi_slave`
- `spi_wr_data`  in  32  write data from `spi_slave`
- `spi_rd_data`  out  32  registered readback data to `spi_slave`
- `spi_wr_en`  in  1  one-cycle write strobe
- `spi_rd_en`  in  1  one-cycle read-complete strobe
- `dpram_rd_addr`  out  DPRAM_AW  DPRAM read address
- `dpram_rd_en`  out  1  DPRAM read strobe
- `dpram_rd_data`  in  32  DPRAM read data
- `irq_src`  in  8  interrupt sources, rising-edge sensitive, synchronous to `clk`
- `irq`  out  1  interrupt output, active high
- `rst_pulse`  out  4  self-clearing reset pulses
- `led`  out  3  LED drive
- `ddc_en`  out  1  DDC enable
- `ddc_lo_freq`  out  32  DDC LO tuning word
- `ddc_lo_freq_upd`  out  1  one-cycle LO tuning-word load strobe
- `i2s_mux_sel`  out  2  audio I2S mux select

## Operation
Register map (an unlisted address reads 0 and ignores writes):
- 0x00 ID: read-only, returns `ID_VALUE`.
- 0x01 RST_CNTRL: writing 1 to bit n (n = 0..3) starts or restarts an `RST_PULSE_LEN`-cycle pulse on `rst_pulse[n]`. Each bit has its own counter. A read returns the current `rst_pulse` state.
- 0x02 IRQ_CNTRL_STATUS:
  - [7:0] status. A rising edge on `irq_src[n]` sets status bit n. Writing 1 clears it (write-1-to-clear).
  - [23:16] enable, read/write.
  - `irq` = OR over (status & enable), registered.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- 0x03 LED_CNTRL: [2:0] read/write, drives `led`.
- 0x10 ADC_DPRAM_CNTRL:
  - [0] AUTO_INC, read/write.
  - [8] BUSY, read-only; 1 while a prefetch is pending.
- 0x11 ADC_DPRAM_ADDR: [DPRAM_AW-1:0] read/write. A write starts a prefetch.
- 0x12 ADC_DPRAM_DATA: read-only, returns the prefetch buffer.
  - `spi_rd_en` at this address with AUTO_INC=1 increments ADC_DPRAM_ADDR and starts a prefetch.
  - The address wraps from 2^DPRAM_AW−1 to 0.
- 0x20 DDC_CNTRL:
  - [0] `ddc_en`, read/write.
  - [1] write-1 produces a one-cycle `ddc_lo_freq_upd`; this bit always reads 0.
- 0x21 DDC_LO_FREQ: 32-bit read/write, drives `ddc_lo_freq`.
- 0x30 AUDIO_I2S_MUX_SEL: [1:0] read/write.

Prefetch state machine, states IDLE, WAIT, CAPTURE:
- IDLE → WAIT on a start. In that cycle, `dpram_rd_en`=1 and `dpram_rd_addr` = the new address. The latency counter loads `DPRAM_RD_LAT`−1.
- WAIT counts down to 0, then → CAPTURE.
- CAPTURE latches `dpram_rd_data` into the buffer, then → IDLE.
- A start while in WAIT or CAPTURE aborts the pending read and restarts WAIT with the newest address. Only the newest address is ever captured.
- BUSY = (state ≠ IDLE).

Reset values:
- All outputs 0.
- All registers 0 (AUTO_INC=0, prefetch buffer=0).
- State machine in IDLE; `spi_rd_data` = 0.
- Reset asserted mid-prefetch returns the state machine to IDLE with no capture.

## Timing
- `spi_rd_data` is registered from the `spi_addr` decode: 1 cycle after the address changes. `spi_slave` must hold `spi_addr` for at least 2 `clk` cycles before sampling. This holds with a 20 MHz `clk` and 5 MHz SCK.
- Write side effects (register update, pulse start, prefetch start) happen on the clock edge that samples `spi_wr_en`. Outputs change 1 cycle later.
- Prefetch latency from start to buffer valid is `DPRAM_RD_LAT`+1 cycles. A burst of consecutive ADC_DPRAM_DATA reads spaced ≥ 8 SCK bits apart always sees a fresh buffer.
- `spi_wr_en` and `spi_rd_en` are never asserted in the same cycle. If they are, `spi_wr_en` takes priority and `spi_rd_en` is ignored.

## Structure
- Package `cntrl_spi_pkg`:
  - `CNTRL_SPI_REG_*` address constants (7 bits).
  - Field bit-index constants.
  - Prefetch state enum.
  - This package is shared with `spi_slave` benches.
- Sub-module `dpram_prefetch`: the prefetch state machine, latency counter and data buffer.
- The top level holds decode, the register storage, the IRQ edge detect and the pulse counters.

## Test plan
- After reset release: read 0x00 → `spi_rd_data` = 32'h1C0A0001. All outputs 0.
- Write 0x02 = 32'h00FF0000, then pulse `irq_src[3]`: `irq`=1 and 0x02 reads 32'h00FF0008. Write 32'h00000008 to 0x02 → `irq`=0. A set and a clear of the same bit in the same cycle → that bit stays 1.
- Write 0x01 = 4'b0101: `rst_pulse[0]` and `rst_pulse[2]` are high for exactly 16 cycles. Rewriting at cycle 10 extends the pulse to 26 cycles total.
- DPRAM model holds mem[i] = 32'hADC00000+i. Write 0x10 = 1 and 0x11 = 12'hFFE, then read 0x12 three times → 32'hADC00FFE, 32'hADC00FFF, 32'hADC00000 (wrap).
- Write 0x11 twice within 2 cycles (addr 5, then 9) → the buffer captures only mem[9]. BUSY reads 1 during the prefetch and 0 afterwards.
- Write 0x21 = 32'h12345678, then 0x20 = 32'h3: `ddc_lo_freq` = 32'h12345678, `ddc_en`=1, `ddc_lo_freq_upd` high for exactly 1 cycle. 0x20 reads back 32'h1. Reset asserted mid-prefetch → state IDLE, all outputs 0.

Source files
------------

// File: rtl/cntrl_spi_pkg.sv
// Register addresses, field positions and prefetch state encoding for the
// SPI control-register file; also used by the spi_slave benches.
package cntrl_spi_pkg;

    localparam logic [6:0] CNTRL_SPI_REG_ID                = 7'h00;
    localparam logic [6:0] CNTRL_SPI_REG_RST_CNTRL         = 7'h01;
    localparam logic [6:0] CNTRL_SPI_REG_IRQ_CNTRL_STATUS  = 7'h02;
    localparam logic [6:0] CNTRL_SPI_REG_LED_CNTRL         = 7'h03;
    localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_CNTRL   = 7'h10;
    localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_ADDR    = 7'h11;
    localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_DATA    = 7'h12;
    localparam logic [6:0] CNTRL_SPI_REG_DDC_CNTRL         = 7'h20;
    localparam logic [6:0] CNTRL_SPI_REG_DDC_LO_FREQ       = 7'h21;
    localparam logic [6:0] CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL = 7'h30;

    localparam int IRQ_STATUS_LSB     = 0;
    localparam int IRQ_ENABLE_LSB     = 16;
    localparam int DPRAM_AUTO_INC_BIT = 0;
    localparam int DPRAM_BUSY_BIT     = 8;
    localparam int DDC_EN_BIT         = 0;
    localparam int DDC_UPD_BIT        = 1;

    typedef enum logic [1:0] {
        PF_IDLE    = 2'd0,
        PF_WAIT    = 2'd1,
        PF_CAPTURE = 2'd2
    } pf_state_e;

endpackage

// File: rtl/dpram_prefetch.sv
// Issues a DPRAM read on start, waits out the RAM latency and captures the
// word into a buffer; a new start always supersedes a pending read.
module dpram_prefetch
    import cntrl_spi_pkg::*;
#(
    parameter int AW     = 12,
    parameter int RD_LAT = 2
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [AW-1:0] start_addr_i,
    output logic [AW-1:0] dpram_rd_addr_o,
    output logic          dpram_rd_en_o,
    input  logic [31:0]   dpram_rd_data_i,
    output logic [31:0]   buf_o,
    output logic          busy_o
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    pf_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (start_i) begin
            state_d = PF_WAIT;
            cnt_d   = LAT_LOAD;
        end else begin
            case (state_q)
                PF_WAIT: begin
                    if (cnt_q == 3'd0) state_d = PF_CAPTURE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                PF_CAPTURE: begin
                    buf_d   = dpram_rd_data_i;
                    state_d = PF_IDLE;
                end
                default: state_d = PF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PF_IDLE;
            cnt_q   <= 3'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // The read is issued combinationally in the start cycle so the RAM
    // latency begins on the same edge that commits the new address.
    assign dpram_rd_en_o   = start_i;
    assign dpram_rd_addr_o = start_addr_i;
    assign buf_o           = buf_q;
    assign busy_o          = (state_q != PF_IDLE);

endmodule

// File: rtl/cntrl_spi_regs.sv
// Control-register file behind spi_slave: address decode, register storage,
// IRQ edge capture, self-clearing reset pulses and the DPRAM prefetcher.
module cntrl_spi_regs
    import cntrl_spi_pkg::*;
#(
    parameter logic [31:0] ID_VALUE      = 32'h1C0A0001,
    parameter int          DPRAM_AW      = 12,
    parameter int          DPRAM_RD_LAT  = 2,
    parameter int          RST_PULSE_LEN = 16
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          spi_addr,
    input  logic [31:0]         spi_wr_data,
    output logic [31:0]         spi_rd_data,
    input  logic                spi_wr_en,
    input  logic                spi_rd_en,
    output logic [DPRAM_AW-1:0] dpram_rd_addr,
    output logic                dpram_rd_en,
    input  logic [31:0]         dpram_rd_data,
    input  logic [7:0]          irq_src,
    output logic                irq,
    output logic [3:0]          rst_pulse,
    output logic [2:0]          led,
    output logic                ddc_en,
    output logic [31:0]         ddc_lo_freq,
    output logic                ddc_lo_freq_upd,
    output logic [1:0]          i2s_mux_sel
);

    localparam logic [7:0] PULSE_LOAD = 8'(RST_PULSE_LEN);

    logic wr_rst, wr_irq, wr_led, wr_dcntrl, wr_daddr, wr_ddc, wr_lo, wr_mux;
    logic rd_inc, pf_start, pf_busy;
    logic [31:0] pf_buf, rd_mux, rd_data_q;
    logic [7:0] status_q, status_d, enable_q, irq_src_q, irq_clr;
    logic irq_q, auto_inc_q, ddc_en_q, upd_q;
    logic [2:0] led_q;
    logic [1:0] mux_q;
    logic [31:0] lo_q;
    logic [DPRAM_AW-1:0] addr_q, addr_d;

    assign wr_rst    = spi_wr_en && (spi_addr == CNTRL_SPI_REG_RST_CNTRL);
    assign wr_irq    = spi_wr_en && (spi_addr == CNTRL_SPI_REG_IRQ_CNTRL_STATUS);
    assign wr_led    = spi_wr_en && (spi_addr == CNTRL_SPI_REG_LED_CNTRL);
    assign wr_dcntrl = spi_wr_en && (spi_addr == CNTRL_SPI_REG_ADC_DPRAM_CNTRL);
    assign wr_daddr  = spi_wr_en && (spi_addr == CNTRL_SPI_REG_ADC_DPRAM_ADDR);
    assign wr_ddc    = spi_wr_en && (spi_addr == CNTRL_SPI_REG_DDC_CNTRL);
    assign wr_lo     = spi_wr_en && (spi_addr == CNTRL_SPI_REG_DDC_LO_FREQ);
    assign wr_mux    = spi_wr_en && (spi_addr == CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL);
    // A write strobe masks a coincident read strobe.
    assign rd_inc    = spi_rd_en && !spi_wr_en && auto_inc_q &&
                       (spi_addr == CNTRL_SPI_REG_ADC_DPRAM_DATA);

    always_comb begin
        addr_d = addr_q;
        if (wr_daddr)    addr_d = spi_wr_data[DPRAM_AW-1:0];
        else if (rd_inc) addr_d = addr_q + DPRAM_AW'(1);
    end
    assign pf_start = wr_daddr || rd_inc;

    // Clearing and a fresh rising edge can coincide; the edge is ORed in last.
    assign irq_clr  = wr_irq ? spi_wr_data[IRQ_STATUS_LSB +: 8] : 8'h00;
    assign status_d = (status_q & ~irq_clr) | (irq_src & ~irq_src_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q   <= 8'h00;
            enable_q   <= 8'h00;
            irq_src_q  <= 8'h00;
            irq_q      <= 1'b0;
            led_q      <= 3'd0;
            auto_inc_q <= 1'b0;
            addr_q     <= '0;
            ddc_en_q   <= 1'b0;
            upd_q      <= 1'b0;
            lo_q       <= 32'd0;
            mux_q      <= 2'd0;
            rd_data_q  <= 32'd0;
        end else begin
            status_q  <= status_d;
            irq_src_q <= irq_src;
            irq_q     <= |(status_q & enable_q);
            addr_q    <= addr_d;
            upd_q     <= wr_ddc && spi_wr_data[DDC_UPD_BIT];
            rd_data_q <= rd_mux;
            if (wr_irq)    enable_q   <= spi_wr_data[IRQ_ENABLE_LSB +: 8];
            if (wr_led)    led_q      <= spi_wr_data[2:0];
            if (wr_dcntrl) auto_inc_q <= spi_wr_data[DPRAM_AUTO_INC_BIT];
            if (wr_ddc)    ddc_en_q   <= spi_wr_data[DDC_EN_BIT];
            if (wr_lo)     lo_q       <= spi_wr_data;
            if (wr_mux)    mux_q      <= spi_wr_data[1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pulse
            logic [7:0] cnt_q, cnt_d;
            logic       pulse_q;

            always_comb begin
                cnt_d = cnt_q;
                if (wr_rst && spi_wr_data[gi]) cnt_d = PULSE_LOAD;
                else if (cnt_q != 8'd0)        cnt_d = cnt_q - 8'd1;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q   <= 8'd0;
                    pulse_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    pulse_q <= (cnt_d != 8'd0);
                end
            end

            assign rst_pulse[gi] = pulse_q;
        end
    endgenerate

    dpram_prefetch #(
        .AW     (DPRAM_AW),
        .RD_LAT (DPRAM_RD_LAT)
    ) u_prefetch (
        .clk             (clk),
        .reset           (reset),
        .start_i         (pf_start),
        .start_addr_i    (addr_d),
        .dpram_rd_addr_o (dpram_rd_addr),
        .dpram_rd_en_o   (dpram_rd_en),
        .dpram_rd_data_i (dpram_rd_data),
        .buf_o           (pf_buf),
        .busy_o          (pf_busy)
    );

    always_comb begin
        rd_mux = 32'd0;
        case (spi_addr)
            CNTRL_SPI_REG_ID:        rd_mux = ID_VALUE;
            CNTRL_SPI_REG_RST_CNTRL: rd_mux[3:0] = rst_pulse;
            CNTRL_SPI_REG_IRQ_CNTRL_STATUS: begin
                rd_mux[IRQ_STATUS_LSB +: 8] = status_q;
                rd_mux[IRQ_ENABLE_LSB +: 8] = enable_q;
            end
            CNTRL_SPI_REG_LED_CNTRL: rd_mux[2:0] = led_q;
            CNTRL_SPI_REG_ADC_DPRAM_CNTRL: begin
                rd_mux[DPRAM_AUTO_INC_BIT] = auto_inc_q;
                rd_mux[DPRAM_BUSY_BIT]     = pf_busy;
            end
            CNTRL_SPI_REG_ADC_DPRAM_ADDR:     rd_mux[DPRAM_AW-1:0] = addr_q;
            CNTRL_SPI_REG_ADC_DPRAM_DATA:     rd_mux = pf_buf;
            CNTRL_SPI_REG_DDC_CNTRL:          rd_mux[DDC_EN_BIT] = ddc_en_q;
            CNTRL_SPI_REG_DDC_LO_FREQ:        rd_mux = lo_q;
            CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL:  rd_mux[1:0] = mux_q;
            default:                          rd_mux = 32'd0;
        endcase
    end

    assign spi_rd_data     = rd_data_q;
    assign irq             = irq_q;
    assign led             = led_q;
    assign ddc_en          = ddc_en_q;
    assign ddc_lo_freq     = lo_q;
    assign ddc_lo_freq_upd = upd_q;
    assign i2s_mux_sel     = mux_q;

endmodule
